ps2_kb_rx: RTL and testbench

Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It oversamples the raw `KB_Clk`/`KB_Data` lines and validates each 11-bit frame (start, parity, stop). It decodes `E0`/`F0` prefixes into tagged make/break events and buffers them in a FIFO with a valid/ready handshake. It sits between the keyboard pins and the processor's I/O register file, and supersedes the edge-clocked keyboard byte latch, which had no parity check, no timeout, no buffering and no release reporting.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_event_fifo.sv | 64 ++++++
 rtl/ps2_kb_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_kb_rx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame receiver states: waiting for start bit, shifting data, parity, stop.
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Scan-code prefixes: extended key and key release.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  localparam int PS2_EV_W = 10;

  // One decoded key event as queued for the processor.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Single-clock event FIFO with occupancy count. A push into a full FIFO is
// still accepted when a pop happens in the same cycle; otherwise it is dropped
// and the caller decides what to flag.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head entry is forced to zero while empty so the output is clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: oversamples the raw keyboard lines, validates each
// 11-bit frame, folds E0/F0 prefixes into tagged events and queues them.
module ps2_kb_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          KB_Clk,
  input  logic                          KB_Data,
  output logic [PS2_EV_W-1:0]           Ev_Data,
  output logic                          Ev_Valid,
  input  logic                          Ev_Ready,
  output logic                          Frame_Err,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Ev_Count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   bit_in;

  ps2_state_t             state;
  ps2_state_t             next_state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   par_bit;
  logic                   start_frame;
  logic                   shift_en;
  logic                   par_en;
  logic                   stop_en;
  logic                   frame_good;

  logic [WD_W-1:0]        wd_cnt;
  logic                   timeout;

  logic                   ext_pend;
  logic                   rel_pend;
  ps2_event_t             ev_q;
  logic                   ev_push_q;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_pop;

  // Synchronizers reset to the idle-high bus level so reset cannot fake an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], KB_Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], KB_Data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev && !clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  // Watchdog: cycles since the last falling edge while a frame is in progress.
  always_ff @(posedge Clk) begin
    if (Reset || state == IDLE || fall || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = (state != IDLE) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // Frame state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; each falling edge advances one bit position.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    if (timeout) begin
      next_state = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            next_state  = DATA;
            start_frame = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            next_state = PARITY;
          end
        end
        PARITY: begin
          par_en     = 1'b1;
          next_state = STOP;
        end
        STOP: begin
          stop_en    = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Data shifter, bit counter and parity capture, LSB first.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      if (start_frame) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt   <= bit_cnt + 3'd1;
        shift_reg <= {bit_in, shift_reg[7:1]};
      end
      if (par_en) begin
        par_bit <= bit_in;
      end
    end
  end

  // Good frame: stop bit high and odd parity across data plus parity bit.
  assign frame_good = bit_in && (^{shift_reg, par_bit});

  // Prefix decode, event registration and the one-cycle error pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ev_q      <= '0;
      ev_push_q <= 1'b0;
      Frame_Err <= 1'b0;
      ext_pend  <= 1'b0;
      rel_pend  <= 1'b0;
    end else begin
      ev_push_q <= 1'b0;
      Frame_Err <= 1'b0;
      if (timeout || (stop_en && !frame_good)) begin
        Frame_Err <= 1'b1;
        ext_pend  <= 1'b0;
        rel_pend  <= 1'b0;
      end else if (stop_en) begin
        if (shift_reg == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (shift_reg == PS2_REL) begin
          rel_pend <= 1'b1;
        end else begin
          ev_q      <= '{ext: ext_pend, rel: rel_pend, code: shift_reg};
          ev_push_q <= 1'b1;
          ext_pend  <= 1'b0;
          rel_pend  <= 1'b0;
        end
      end
    end
  end

  assign fifo_pop = Ev_Valid && Ev_Ready;
  assign Ev_Valid = !fifo_empty;

  // Sticky flag for events lost to a full queue.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (ev_push_q && fifo_full && !fifo_pop) begin
      Overflow <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .WIDTH (PS2_EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (ev_push_q),
    .push_data (ev_q),
    .pop       (fifo_pop),
    .rd_data   (Ev_Data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (Ev_Count)
  );

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Scoreboard bench for ps2_kb_rx: frames are bit-banged on the PS/2 lines,
// a byte-level model predicts events, and a monitor checks every pop.
module tb_ps2_kb_rx;

  localparam int TIMEOUT = 200;
  localparam int DEPTH   = 4;
  localparam int HALF    = 25;
  localparam int GAP     = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       kb_clk;
  logic       kb_data;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;
  logic       frame_err;
  logic       overflow;
  logic [2:0] ev_count;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [9:0] exp_q[$];
  bit         m_ext = 1'b0;
  bit         m_rel = 1'b0;
  int         exp_err = 0;
  int         seen_err = 0;
  int         err_len = 0;
  int         ready_mode = 0;

  ps2_kb_rx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .KB_Clk    (kb_clk),
    .KB_Data   (kb_data),
    .Ev_Data   (ev_data),
    .Ev_Valid  (ev_valid),
    .Ev_Ready  (ev_ready),
    .Frame_Err (frame_err),
    .Overflow  (overflow),
    .Ev_Count  (ev_count)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int unsigned actual,
                             input int unsigned expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data settles while the clock is high, keyboard drops the clock.
  task automatic sendBit(input logic b);
    kb_data = b;
    waitCycles(HALF);
    kb_clk = 1'b0;
    waitCycles(HALF);
    kb_clk = 1'b1;
  endtask

  // Byte-level reference: prefixes set flags, other codes become events.
  task automatic modelByte(input logic [7:0] b, input bit good, input bit keep);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      if (keep) exp_q.push_back({m_ext, m_rel, b});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  // Full 11-bit frame, optionally with a corrupted parity or stop bit.
  task automatic applyStimulus(input logic [7:0] b, input bit bad_par,
                               input bit bad_stop, input bit keep);
    modelByte(b, !(bad_par || bad_stop), keep);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit((~^b) ^ bad_par);
    sendBit(!bad_stop);
    kb_data = 1'b1;
    waitCycles(GAP);
  endtask

  task automatic waitDrain();
    int budget = 0;
    while (exp_q.size() > 0 && budget < 3000) begin
      waitCycles(1);
      budget++;
    end
    waitCycles(5);
    checkOutput("drain_left", exp_q.size(), 0);
  endtask

  // Consumer ready: held low, held high, or random per cycle.
  initial begin
    ev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Event monitor: every pop must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_event: got %0h, expected none", ev_data);
      end else begin
        checkOutput("event", ev_data, exp_q.pop_front());
      end
    end
  end

  // Error monitor: count pulses and require each to last one cycle.
  always @(negedge clk) begin
    if (reset) begin
      err_len = 0;
    end else if (frame_err) begin
      if (err_len == 0) seen_err++;
      err_len++;
    end else if (err_len != 0) begin
      checkOutput("err_width", err_len, 1);
      err_len = 0;
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    bit         bp;
    bit         bs;

    reset   = 1'b1;
    kb_clk  = 1'b1;
    kb_data = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("rst_valid", ev_valid, 0);
    checkOutput("rst_count", ev_count, 0);
    checkOutput("rst_data", ev_data, 0);
    checkOutput("rst_err", frame_err, 0);
    checkOutput("rst_ovf", overflow, 0);

    $display("[TB] single make code");
    applyStimulus(8'h1C, 0, 0, 1);
    waitCycles(20);
    checkOutput("t1_valid", ev_valid, 1);
    checkOutput("t1_data", ev_data, 10'h01C);
    checkOutput("t1_count", ev_count, 1);
    ready_mode = 1;
    waitCycles(5);
    checkOutput("t1_count_after", ev_count, 0);
    checkOutput("t1_valid_after", ev_valid, 0);

    $display("[TB] prefix sequences");
    applyStimulus(8'hF0, 0, 0, 1);
    applyStimulus(8'h1C, 0, 0, 1);
    applyStimulus(8'hE0, 0, 0, 1);
    applyStimulus(8'hF0, 0, 0, 1);
    applyStimulus(8'h75, 0, 0, 1);
    waitDrain();
    checkOutput("t2_errs", seen_err, exp_err);

    $display("[TB] bad parity clears prefix");
    applyStimulus(8'hF0, 0, 0, 1);
    applyStimulus(8'h1C, 1, 0, 1);
    applyStimulus(8'h32, 0, 0, 1);
    waitDrain();
    checkOutput("t3_errs", seen_err, exp_err);

    $display("[TB] watchdog timeout");
    applyStimulus(8'hF0, 0, 0, 1);
    exp_err++;
    m_ext = 1'b0;
    m_rel = 1'b0;
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    kb_data = 1'b1;
    waitCycles(150);
    checkOutput("t4_errs_early", seen_err, exp_err - 1);
    waitCycles(150);
    checkOutput("t4_errs", seen_err, exp_err);
    applyStimulus(8'h2B, 0, 0, 1);
    waitDrain();

    $display("[TB] overflow");
    ready_mode = 0;
    waitCycles(3);
    applyStimulus(8'h16, 0, 0, 1);
    applyStimulus(8'h1E, 0, 0, 1);
    applyStimulus(8'h26, 0, 0, 1);
    applyStimulus(8'h25, 0, 0, 1);
    applyStimulus(8'h2E, 0, 0, 0);
    waitCycles(10);
    checkOutput("t5_count", ev_count, DEPTH);
    checkOutput("t5_ovf", overflow, 1);
    checkOutput("t5_head", ev_data, 10'h016);
    ready_mode = 1;
    waitDrain();
    checkOutput("t5_ovf_sticky", overflow, 1);

    $display("[TB] reset mid-frame");
    b = 8'h1C;
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(b[i]);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    kb_data = 1'b1;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
    waitCycles(1);
    checkOutput("t6_valid", ev_valid, 0);
    checkOutput("t6_count", ev_count, 0);
    checkOutput("t6_data", ev_data, 0);
    checkOutput("t6_ovf", overflow, 0);
    waitCycles(TIMEOUT + 50);
    checkOutput("t6_errs", seen_err, exp_err);
    applyStimulus(8'h1C, 0, 0, 1);
    waitDrain();

    $display("[TB] random frames");
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        b = 8'hE0;
      end else if (r < 40) begin
        b = 8'hF0;
      end else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
      end
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 19) == 0);
      applyStimulus(b, bp, bs, 1);
    end
    ready_mode = 1;
    waitDrain();
    checkOutput("rand_errs", seen_err, exp_err);
    checkOutput("final_count", ev_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
